scd_sc_fe: RTL

Shift-count / floating-exponent datapath for the EBOX. It holds the 10-bit SC (shift count) and FE (floating exponent) registers and a 10-bit SCAD adder. It generates the `SCD_ARMMupper`/`SCD_ARMMlower` fields that the EDP AR/ARL muxes load through select 000. It also provides the count-down and loop-termination flags that byte, shift, multiply and divide microcode loops sequence on.

---
 rtl/scd_sc_fe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/scd_sc_fe.sv
// scd_sc_fe: shift-count / floating-exponent datapath for the EBOX.
// Holds the SC and FE registers, the SCAD adder with its operand muxes,
// the ARMM fields presented to the EDP AR/ARL muxes, and the loop
// termination pulse used by byte, shift, multiply and divide loops.
// Bit numbering follows the KL10 convention: bit 0 is the MSB.
module scd_sc_fe (
  input  logic        eboxClk,
  input  logic        eboxResetN,
  input  logic [0:2]  CRAM_SCAD,
  input  logic [0:1]  CRAM_SCADA,
  input  logic        CRAM_SCADA_EN,
  input  logic [0:1]  CRAM_SCADB,
  input  logic [0:1]  CRAM_SC,
  input  logic [0:1]  CRAM_FE,
  input  logic [0:1]  CRAM_ARMM,
  input  logic [0:8]  CRAM_MAGIC,
  input  logic        CTL_SCstep,
  input  logic [0:35] EDP_AR,
  input  logic [13:17] VMA_section,
  output logic [0:9]  SCD_SC,
  output logic [0:9]  SCD_FE,
  output logic [0:9]  SCD_SCAD,
  output logic        SCD_SCADsign,
  output logic        SCD_SCADzero,
  output logic        SCD_SCsign,
  output logic        SCD_FEsign,
  output logic        SCD_loopDone,
  output logic [0:8]  SCD_ARMMupper,
  output logic [13:17] SCD_ARMMlower
);

  // SCAD function codes.
  localparam logic [0:2] FN_A      = 3'b000;
  localparam logic [0:2] FN_AMBM1  = 3'b001;
  localparam logic [0:2] FN_APB    = 3'b010;
  localparam logic [0:2] FN_AM1    = 3'b011;
  localparam logic [0:2] FN_AP1    = 3'b100;
  localparam logic [0:2] FN_AMB    = 3'b101;
  localparam logic [0:2] FN_OR     = 3'b110;
  localparam logic [0:2] FN_AND    = 3'b111;

  // SC / FE load selects.
  localparam logic [0:1] SC_HOLD_STEP = 2'b00;
  localparam logic [0:1] SC_SCAD      = 2'b01;
  localparam logic [0:1] SC_AR        = 2'b10;
  localparam logic [0:1] SC_ZERO      = 2'b11;
  localparam logic [0:1] FE_SCAD      = 2'b01;
  localparam logic [0:1] FE_ZERO      = 2'b10;

  logic [0:9] sc;
  logic [0:9] fe;
  logic       loop_done;
  logic [0:9] scada;
  logic [0:9] scadb;
  logic [0:9] scad;
  logic [0:9] magic_ext;
  logic       step_wraps;

  assign magic_ext = {CRAM_MAGIC[0], CRAM_MAGIC};

  // SCAD A-operand mux; a disabled A path reads as zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    scada = '0;
    if (CRAM_SCADA_EN) begin
      case (CRAM_SCADA)
        2'b00:   scada = fe;
        2'b01:   scada = {4'b0, EDP_AR[0:5]};
        2'b10:   scada = {2'b0, EDP_AR[1:8] ^ {8{EDP_AR[0]}}};
        default: scada = magic_ext;
      endcase
    end
  end

  // SCAD B-operand mux.
  always_comb begin
    scadb = '0;
    case (CRAM_SCADB)
      2'b00:   scadb = sc;
      2'b01:   scadb = {4'b0, EDP_AR[6:11]};
      2'b10:   scadb = {EDP_AR[0], EDP_AR[0:8]};
      default: scadb = magic_ext;
    endcase
  end

  // SCAD function unit; all arithmetic wraps modulo 2^10.
  always_comb begin
    scad = '0;
    case (CRAM_SCAD)
      FN_A:     scad = scada;
      FN_AMBM1: scad = scada + ~scadb;
      FN_APB:   scad = scada + scadb;
      FN_AM1:   scad = scada - 10'd1;
      FN_AP1:   scad = scada + 10'd1;
      FN_AMB:   scad = scada - scadb;
      FN_OR:    scad = scada | scadb;
      default:  scad = scada & scadb;
    endcase
  end

  // A step from SC==0 is the one that ends the loop (SC goes to -1).
  assign step_wraps = (CRAM_SC == SC_HOLD_STEP) && CTL_SCstep && (sc == 10'h000);

  // SC register: any load overrides a step; otherwise step or hold.
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values, matching the hardware.
      sc <= '0;
    end else begin
      case (CRAM_SC)
        SC_SCAD: sc <= scad;
        SC_AR:   sc <= {EDP_AR[18], EDP_AR[27:35]};
        SC_ZERO: sc <= '0;
        default: if (CTL_SCstep) sc <= sc - 10'd1;
      endcase
    end
  end

  // FE register: load from SCAD, clear, or hold.
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      fe <= '0;
    end else begin
      case (CRAM_FE)
        FE_SCAD: fe <= scad;
        FE_ZERO: fe <= '0;
        default: fe <= fe;
      endcase
    end
  end

  // Loop-done pulse: high for the single cycle in which SC has just become -1.
  always_ff @(posedge eboxClk or negedge eboxResetN) begin
    if (!eboxResetN) begin
      loop_done <= 1'b0;
    end else begin
      loop_done <= step_wraps;
    end
  end

  // ARMM field mux feeding the EDP AR/ARL select-000 path.
  always_comb begin
    SCD_ARMMupper = CRAM_MAGIC;
    SCD_ARMMlower = '0;
    case (CRAM_ARMM)
      2'b00:   SCD_ARMMupper = CRAM_MAGIC;
      2'b01:   SCD_ARMMupper = scad[1:9];
      2'b10:   SCD_ARMMupper = fe[1:9];
      default: begin
        SCD_ARMMupper = {9{EDP_AR[0]}};
        SCD_ARMMlower = VMA_section;
      end
    endcase
  end

  assign SCD_SC       = sc;
  assign SCD_FE       = fe;
  assign SCD_SCAD     = scad;
  assign SCD_SCADsign = scad[0];
  assign SCD_SCADzero = (scad == 10'h000);
  assign SCD_SCsign   = sc[0];
  assign SCD_FEsign   = fe[0];
  assign SCD_loopDone = loop_done;

endmodule
